lu_sequencer: RTL

LU_SEQUENCER -- requirements
Module: lu_sequencer

---
 rtl/lu_pkg.sv | 15 +
 rtl/lu_core.sv | 26 ++
 rtl/lu_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared types and op-code constants for the logic-unit sequencer.
package lu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LE    = 2'd0;
  localparam logic [1:0] OP_AODD  = 2'd1;
  localparam logic [1:0] OP_BODD  = 2'd2;
  localparam logic [1:0] OP_CARRY = 2'd3;

endpackage

// File: rtl/lu_core.sv
// Combinational logic unit: evaluates one of four single-bit predicates on a, b.
module lu_core
  import lu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] sel,
  output logic       flag
);

  logic [4:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    flag = 1'b0;
    case (sel)
      OP_LE:    flag = (a <= b);
      OP_AODD:  flag = a[0];
      OP_BODD:  flag = b[0];
      OP_CARRY: flag = sum[4];
      default:  flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/lu_sequencer.sv
// Steps through the enabled ops of a registered request on lu_core, holding each
// for OP_CYCLES cycles, and presents the collected flags with a valid/ready handshake.
module lu_sequencer
  import lu_pkg::*;
#(
  parameter int unsigned OP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] op_mask,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] flags,
  output logic       busy,
  output logic [1:0] cur_op
);

  localparam logic [3:0] CNT_LOAD = 4'(OP_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] a_r, a_n;
  logic [3:0] b_r, b_n;
  logic [3:0] mask_r, mask_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] cur_r, cur_n;
  logic [3:0] flags_r, flags_n;

  logic [1:0] first_op;
  logic [1:0] next_op;
  logic       has_next;
  logic       core_flag;

  lu_core u_core (
    .a    (a_r),
    .b    (b_r),
    .sel  (cur_r),
    .flag (core_flag)
  );

  // Priority encoders: lowest set bit of the incoming mask, and the lowest
  // set bit of the registered mask strictly above the current op.
  always_comb begin
    first_op = '0;
    next_op  = '0;
    has_next = 1'b0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (op_mask[i-1]) first_op = 2'(i - 1);
      if (mask_r[i-1] && (2'(i - 1) > cur_r)) begin
        next_op  = 2'(i - 1);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_r;
    b_n     = b_r;
    mask_n  = mask_r;
    cnt_n   = cnt;
    cur_n   = cur_r;
    flags_n = flags_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_n     = a;
          b_n     = b;
          mask_n  = op_mask;
          flags_n = '0;
          if (op_mask != '0) begin
            cur_n   = first_op;
            cnt_n   = CNT_LOAD;
            state_n = RUN;
          end else begin
            state_n = DONE;
          end
        end
      end
      RUN: begin
        if (cnt == '0) begin
          flags_n[cur_r] = core_flag;
          if (has_next) begin
            cur_n = next_op;
            cnt_n = CNT_LOAD;
          end else begin
            cur_n   = '0;
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      mask_r  <= '0;
      cnt     <= '0;
      cur_r   <= '0;
      flags_r <= '0;
    end else begin
      state   <= state_n;
      a_r     <= a_n;
      b_r     <= b_n;
      mask_r  <= mask_n;
      cnt     <= cnt_n;
      cur_r   <= cur_n;
      flags_r <= flags_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign cur_op    = cur_r;
  assign flags     = flags_r;

endmodule
